soc_ascon_io: RTL and testbench

Parametrised bus-side I/O engine between the picosoc CPU and the Ascon AEAD core. It replaces the fixed-timing byte-lane encryption wrapper. It buffers key, nonce, associated data, text and an expected tag through word-indexed writes, and starts the core in encrypt or decrypt mode. On completion it streams the result out under a valid/ready handshake, and in decrypt mode it performs tag verification with plaintext suppression.

---
 rtl/soc_ascon_pkg.sv | 23 ++
 rtl/ascon_out_serializer.sv | 56 +++++
 rtl/soc_ascon_io.sv | 199 +++++++++++++++++++
 tb/tb_soc_ascon_io.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ascon_pkg.sv
// soc_ascon_pkg: shared constants for the Ascon bus-side I/O engine.
// Holds the write-field codes, the operating-mode encodings and the
// controller state enum used by soc_ascon_io.
package soc_ascon_pkg;

   // Write-field selectors carried on wr_field (codes 5..7 are unused).
   localparam logic [2:0] FLD_KEY   = 3'd0;
   localparam logic [2:0] FLD_NONCE = 3'd1;
   localparam logic [2:0] FLD_AD    = 3'd2;
   localparam logic [2:0] FLD_TEXT  = 3'd3;
   localparam logic [2:0] FLD_TAG   = 3'd4;

   // Operation mode latched with start.
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ascon_out_serializer.sv
// ascon_out_serializer: parallel-load shifter that streams a result word
// out MSB-first, OUT_W bits per beat, under a valid/ready handshake.
// Ports: load/load_data/load_beats (parallel load), out_valid/out_ready/
// out_data/out_last (stream), last_acc (final beat accepted this cycle).
module ascon_out_serializer #(
   parameter int STREAM_W = 256,
   parameter int OUT_W    = 8,
   parameter int CNT_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [STREAM_W-1:0] load_data,
   input  logic [CNT_W-1:0]    load_beats,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_last,
   output logic                last_acc
);

   logic [STREAM_W-1:0] shreg;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    nbeats;
   logic                vld;
   logic                fire;

   assign out_valid = vld;
   assign out_data  = shreg[STREAM_W-1 -: OUT_W];
   assign out_last  = vld && (cnt == (nbeats - CNT_W'(1)));
   assign fire      = vld && out_ready;
   assign last_acc  = fire && out_last;

   // Data only moves on an accepted beat, so out_data holds while stalled.
   // Shifting in zeros leaves out_data at 0 once the stream is exhausted.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg  <= '0;
         cnt    <= '0;
         nbeats <= '0;
         vld    <= 1'b0;
      end else if (load) begin
         shreg  <= load_data;
         nbeats <= load_beats;
         cnt    <= '0;
         vld    <= 1'b1;
      end else if (fire) begin
         shreg <= shreg << OUT_W;
         cnt   <= cnt + CNT_W'(1);
         if (out_last) begin
            vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/soc_ascon_io.sv
// soc_ascon_io: bus-side I/O engine for the Ascon AEAD core. Buffers key,
// nonce, AD, text and expected tag via word-indexed strobed writes, kicks
// the core, then streams the result; decrypt checks the tag and zeroes the
// plaintext on mismatch.
// Ports: wr_* (buffer writes, IDLE only), start/mode (request), busy/done/
// auth_ok (status), core_* (core interface), out_* (result stream).
module soc_ascon_io #(
   parameter int k     = 128,
   parameter int l     = 128,
   parameter int y     = 128,
   parameter int BUS_W = 32,
   parameter int OUT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [2:0]         wr_field,
   input  logic [7:0]         wr_index,
   input  logic [BUS_W/8-1:0] wr_strb,
   input  logic [BUS_W-1:0]   wr_data,
   input  logic               start,
   input  logic               mode,
   output logic               busy,
   output logic               done,
   output logic               auth_ok,
   output logic               core_start,
   output logic               core_mode,
   output logic [k-1:0]       core_key,
   output logic [127:0]       core_nonce,
   output logic [l-1:0]       core_ad,
   output logic [y-1:0]       core_text,
   output logic [127:0]       core_tag,
   input  logic               core_done,
   input  logic [y-1:0]       core_text_out,
   input  logic [127:0]       core_tag_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_last
);
   import soc_ascon_pkg::*;

   localparam int SB        = BUS_W / 8;
   localparam int KW        = k / BUS_W;
   localparam int NW        = 128 / BUS_W;
   localparam int LW        = l / BUS_W;
   localparam int YW        = y / BUS_W;
   localparam int STREAM_W  = y + 128;
   localparam int ENC_BEATS = STREAM_W / OUT_W;
   localparam int DEC_BEATS = y / OUT_W;
   localparam int CNT_W     = $clog2(ENC_BEATS) + 1;

   generate
      if ((BUS_W % 8) != 0 || (k % BUS_W) != 0 || (l % BUS_W) != 0 ||
          (y % BUS_W) != 0 || (128 % BUS_W) != 0) begin : g_bad_bus
         $error("soc_ascon_io: k, l, y and 128 must be multiples of BUS_W");
      end
      if ((y % OUT_W) != 0) begin : g_bad_out
         $error("soc_ascon_io: OUT_W must divide y");
      end
   endgenerate

   state_t               state;
   state_t               state_nxt;
   logic                 load;
   logic                 last_acc;
   logic                 wr_ok;
   logic                 tag_match;
   logic [STREAM_W-1:0]  load_data;
   logic [CNT_W-1:0]     load_beats;

   logic [k-1:0]   key_buf;
   logic [127:0]   nonce_buf;
   logic [l-1:0]   ad_buf;
   logic [y-1:0]   text_buf;
   logic [127:0]   tag_buf;

   assign busy       = (state != ST_IDLE);
   assign core_key   = key_buf;
   assign core_nonce = nonce_buf;
   assign core_ad    = ad_buf;
   assign core_text  = text_buf;
   assign core_tag   = tag_buf;

   // Buffers are writable only in IDLE, which also freezes them for the core.
   assign wr_ok = wr_en && (state == ST_IDLE);

   // Word i sits MSB-first; strobe bit j enables data byte [8j+7:8j] of that
   // word. Unmatched field codes or indices simply hit no byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_buf   <= '0;
         nonce_buf <= '0;
         ad_buf    <= '0;
         text_buf  <= '0;
         tag_buf   <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < KW; i++)
            for (int j = 0; j < SB; j++)
               if (wr_field == FLD_KEY && int'(wr_index) == i && wr_strb[j])
                  key_buf[(KW-1-i)*BUS_W + j*8 +: 8] <= wr_data[j*8 +: 8];
         for (int i = 0; i < NW; i++)
            for (int j = 0; j < SB; j++)
               if (wr_field == FLD_NONCE && int'(wr_index) == i && wr_strb[j])
                  nonce_buf[(NW-1-i)*BUS_W + j*8 +: 8] <= wr_data[j*8 +: 8];
         for (int i = 0; i < LW; i++)
            for (int j = 0; j < SB; j++)
               if (wr_field == FLD_AD && int'(wr_index) == i && wr_strb[j])
                  ad_buf[(LW-1-i)*BUS_W + j*8 +: 8] <= wr_data[j*8 +: 8];
         for (int i = 0; i < YW; i++)
            for (int j = 0; j < SB; j++)
               if (wr_field == FLD_TEXT && int'(wr_index) == i && wr_strb[j])
                  text_buf[(YW-1-i)*BUS_W + j*8 +: 8] <= wr_data[j*8 +: 8];
         for (int i = 0; i < NW; i++)
            for (int j = 0; j < SB; j++)
               if (wr_field == FLD_TAG && int'(wr_index) == i && wr_strb[j])
                  tag_buf[(NW-1-i)*BUS_W + j*8 +: 8] <= wr_data[j*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (core_done) begin
               state_nxt = ST_DRAIN;
               load      = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (last_acc) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign tag_match = (core_tag_out == tag_buf);

   // Encrypt streams text then tag. Decrypt streams only the text portion
   // (upper y bits); a tag mismatch loads zeros so no plaintext escapes.
   always_comb begin
      load_data  = '0;
      load_beats = CNT_W'(ENC_BEATS);
      if (core_mode == MODE_ENC) begin
         load_data = {core_text_out, core_tag_out};
      end else begin
         load_beats = CNT_W'(DEC_BEATS);
         if (tag_match) load_data = {core_text_out, {128{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         core_start <= 1'b0;
         core_mode  <= MODE_ENC;
         auth_ok    <= 1'b0;
         done       <= 1'b0;
      end else begin
         core_start <= (state == ST_IDLE) && start;
         done       <= (state == ST_DRAIN) && last_acc;
         if ((state == ST_IDLE) && start) begin
            core_mode <= mode;
            auth_ok   <= 1'b0;
         end else if (load && (core_mode == MODE_DEC)) begin
            auth_ok <= tag_match;
         end
      end
   end

   ascon_out_serializer #(
      .STREAM_W (STREAM_W),
      .OUT_W    (OUT_W),
      .CNT_W    (CNT_W)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_data),
      .load_beats (load_beats),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .last_acc   (last_acc)
   );

endmodule

// File: tb/tb_soc_ascon_io.sv
// tb_soc_ascon_io: self-checking bench for soc_ascon_io with default
// parameters. A byte-array model of the buffers predicts every result; a
// simple core stand-in answers core_start after ten cycles.
module tb_soc_ascon_io;
   import soc_ascon_pkg::*;

   logic         clk, rst;
   logic         wr_en;
   logic [2:0]   wr_field;
   logic [7:0]   wr_index;
   logic [3:0]   wr_strb;
   logic [31:0]  wr_data;
   logic         start, mode;
   logic         busy, done, auth_ok, core_start, core_mode;
   logic [127:0] core_key, core_nonce, core_ad, core_text, core_tag;
   logic         core_done;
   logic [127:0] ct_out, tg_out;
   logic         out_valid, out_ready, out_last;
   logic [7:0]   out_data;

   soc_ascon_io dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_field(wr_field), .wr_index(wr_index),
      .wr_strb(wr_strb), .wr_data(wr_data), .start(start), .mode(mode),
      .busy(busy), .done(done), .auth_ok(auth_ok), .core_start(core_start),
      .core_mode(core_mode), .core_key(core_key), .core_nonce(core_nonce),
      .core_ad(core_ad), .core_text(core_text), .core_tag(core_tag),
      .core_done(core_done), .core_text_out(ct_out), .core_tag_out(tg_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cs_cnt = 0;
   int dn_cnt = 0;
   logic [7:0] got[$];

   // Model: five buffers of 16 bytes, byte 0 = most significant.
   logic [7:0] mb [0:4][0:15];

   task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
      end
   endtask

   function automatic logic [127:0] pk(input int f);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r = {r[119:0], mb[f][i]};
      return r;
   endfunction

   task automatic mclear();
      for (int f = 0; f < 5; f++)
         for (int i = 0; i < 16; i++) mb[f][i] = 8'h00;
   endtask

   // Lane L counts from the MSB byte of the bus word; its strobe is strb[3-L].
   task automatic mwrite(input logic [2:0] f, input logic [7:0] idx, input logic [3:0] s,
                         input logic [31:0] d);
      if (f <= 3'd4 && idx < 8'd4)
         for (int L = 0; L < 4; L++)
            if (s[3-L]) mb[f][int'(idx)*4 + L] = d[31-8*L -: 8];
   endtask

   task automatic wr(input logic [2:0] f, input logic [7:0] i, input logic [3:0] s,
                     input logic [31:0] d);
      wr_en = 1'b1; wr_field = f; wr_index = i; wr_strb = s; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      mwrite(f, i, s, d);
   endtask

   task automatic chk_bufs(input string nm);
      chk(nm, {core_key, core_nonce, core_ad, core_text, core_tag},
          {pk(0), pk(1), pk(2), pk(3), pk(4)});
   endtask

   always @(negedge clk) begin
      if (core_start) cs_cnt++;
      if (done) dn_cnt++;
   end

   // Core stand-in: answers ten cycles after core_start unless reset hits.
   initial begin
      bit ab;
      core_done = 1'b0; ct_out = '0; tg_out = '0;
      forever begin
         @(negedge clk);
         if (core_start && !rst) begin
            ab = 1'b0;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               if (rst) ab = 1'b1;
            end
            if (!ab) begin
               #1;
               ct_out    = core_text ^ {16{8'hA5}};
               tg_out    = core_key ^ core_nonce;
               core_done = 1'b1;
               @(negedge clk);
               #1 core_done = 1'b0;
            end
         end
      end
   end

   // One full operation. pat: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
   // ign drives writes and start during RUN; abort_at resets at that beat.
   task automatic run_op(input logic md, input int pat, input bit ign, input int abort_at,
                         input bit cw, input logic [2:0] cwf, input logic [7:0] cwi,
                         input logic [3:0] cws, input logic [31:0] cwd);
      int cs0, dn0, n, b, cyc;
      bit seen, r, au;
      logic [7:0] xq[$];
      cs0 = cs_cnt; dn0 = dn_cnt;
      got.delete();
      start = 1'b1; mode = md;
      if (cw) begin
         wr_en = 1'b1; wr_field = cwf; wr_index = cwi; wr_strb = cws; wr_data = cwd;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (cw) mwrite(cwf, cwi, cws, cwd);
      chk("busy_t1", busy, 1);
      chk("core_start_t1", core_start, 1);
      chk("core_mode", core_mode, md);
      au = 1'b1;
      for (int i = 0; i < 16; i++) if (mb[4][i] != (mb[0][i] ^ mb[1][i])) au = 1'b0;
      for (int i = 0; i < 16; i++)
         xq.push_back((md == MODE_DEC && !au) ? 8'h00 : (mb[3][i] ^ 8'hA5));
      if (md == MODE_ENC)
         for (int i = 0; i < 16; i++) xq.push_back(mb[0][i] ^ mb[1][i]);
      n = xq.size();
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 100) begin
         if (ign && cyc < 3) begin
            start = 1'b1; wr_en = 1'b1; wr_field = FLD_KEY; wr_index = 8'd0;
            wr_strb = 4'hF; wr_data = $urandom;
         end else begin
            start = 1'b0; wr_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("core_start_t2", core_start, 0);
         seen = core_done;
      end
      start = 1'b0; wr_en = 1'b0;
      if (!seen) begin
         chk("core_done_timeout", 0, 1);
         return;
      end
      chk("valid_d1", out_valid, 1);
      chk("auth_ok", auth_ok, (md == MODE_DEC) ? au : 1'b0);
      b = 0; cyc = 0;
      while (b < n && cyc < 2000) begin
         chk("beat_valid", out_valid, 1);
         chk("beat_data", out_data, xq[b]);
         chk("beat_last", out_last, (b == n-1));
         if (b == abort_at) begin
            rst = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            chk("abort_outs", {busy, done, auth_ok, core_start, core_mode, out_valid,
                               out_last, out_data}, 0);
            chk("abort_bufs", core_key | core_nonce | core_ad | core_text | core_tag, 0);
            rst = 1'b0;
            mclear();
            repeat (3) @(negedge clk);
            chk("abort_no_done", dn_cnt - dn0, 0);
            chk("abort_idle", {busy, out_valid}, 0);
            return;
         end
         case (pat)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = ($urandom_range(0, 1) != 0);
         endcase
         out_ready = r;
         if (r) got.push_back(out_data);
         @(negedge clk);
         if (r) b++;
         cyc++;
      end
      out_ready = 1'b0;
      chk("drain_count", b, n);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_valid", out_valid, 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("core_start_once", cs_cnt - cs0, 1);
      chk("done_once", dn_cnt - dn0, 1);
      chk_bufs("bufs_after_op");
   endtask

   typedef struct {
      logic [2:0]   fld;
      logic [7:0]   idx;
      logic [3:0]   strb;
      logic [31:0]  dat;
      int           sel;
      logic [127:0] expv;
   } wvec_t;

   wvec_t tv[$];
   logic [127:0] obs;
   logic [31:0]  tw;

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_field = '0; wr_index = '0; wr_strb = '0; wr_data = '0;
      start = 1'b0; mode = 1'b0; out_ready = 1'b0;
      mclear();
      // Cumulative writes from the reset state with hand-derived results.
      tv.push_back('{FLD_KEY,   8'd0,   4'b0101, 32'hDEADBEEF, 0, 128'h00AD00EF_00000000_00000000_00000000});
      tv.push_back('{3'd6,      8'd0,   4'b1111, 32'hFFFFFFFF, 0, 128'h00AD00EF_00000000_00000000_00000000});
      tv.push_back('{FLD_KEY,   8'd200, 4'b1111, 32'hFFFFFFFF, 0, 128'h00AD00EF_00000000_00000000_00000000});
      tv.push_back('{FLD_KEY,   8'd4,   4'b1111, 32'hFFFFFFFF, 0, 128'h00AD00EF_00000000_00000000_00000000});
      tv.push_back('{FLD_KEY,   8'd3,   4'b1111, 32'h11223344, 0, 128'h00AD00EF_00000000_00000000_11223344});
      tv.push_back('{FLD_KEY,   8'd0,   4'b1000, 32'h12345678, 0, 128'h12AD00EF_00000000_00000000_11223344});
      tv.push_back('{FLD_NONCE, 8'd1,   4'b0011, 32'hCAFEF00D, 1, 128'h00000000_0000F00D_00000000_00000000});
      tv.push_back('{FLD_AD,    8'd2,   4'b1111, 32'hA1B2C3D4, 2, 128'h00000000_00000000_A1B2C3D4_00000000});
      tv.push_back('{FLD_TEXT,  8'd0,   4'b0000, 32'hFFFFFFFF, 3, 128'h0});
      tv.push_back('{FLD_TAG,   8'd3,   4'b0110, 32'h01234567, 4, 128'h00000000_00000000_00000000_00234500});
      tv.push_back('{3'd7,      8'd1,   4'b1111, 32'hFFFFFFFF, 4, 128'h00000000_00000000_00000000_00234500});

      repeat (3) @(negedge clk);
      chk("reset_outs", {busy, done, auth_ok, core_start, core_mode, out_valid, out_last, out_data}, 0);
      chk("reset_bufs", core_key | core_nonce | core_ad | core_text | core_tag, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < tv.size(); t++) begin
         wr(tv[t].fld, tv[t].idx, tv[t].strb, tv[t].dat);
         case (tv[t].sel)
            0: obs = core_key;
            1: obs = core_nonce;
            2: obs = core_ad;
            3: obs = core_text;
            default: obs = core_tag;
         endcase
         chk($sformatf("wvec%0d", t), obs, tv[t].expv);
         chk($sformatf("wvec%0d_all", t), {core_key, core_nonce, core_ad, core_text, core_tag},
             {pk(0), pk(1), pk(2), pk(3), pk(4)});
      end

      // Encrypt with the reference key/nonce and zero text.
      for (int w = 0; w < 4; w++) begin
         tw = 32'h00010203 + 32'h04040404 * w;
         wr(FLD_KEY, 8'(w), 4'hF, tw);
         wr(FLD_NONCE, 8'(w), 4'hF, tw ^ 32'h10101010);
         wr(FLD_TEXT, 8'(w), 4'hF, 32'h0);
      end
      run_op(MODE_ENC, 0, 0, -1, 0, 3'd0, 8'd0, 4'h0, 32'h0);
      chk("enc_beats", got.size(), 32);
      chk("enc_beat0", got[0], 8'hA5);
      chk("enc_beat15", got[15], 8'hA5);
      chk("enc_tag0", got[16], 8'h10);
      chk("enc_tag31", got[31], 8'h10);

      // Decrypt, matching tag; last tag word written together with start.
      for (int w = 0; w < 3; w++) wr(FLD_TAG, 8'(w), 4'hF, 32'h10101010);
      run_op(MODE_DEC, 0, 0, -1, 1, FLD_TAG, 8'd3, 4'hF, 32'h10101010);
      chk("dec_ok_auth", auth_ok, 1);
      chk("dec_ok_beats", got.size(), 16);
      chk("dec_ok_beat7", got[7], 8'hA5);

      // Decrypt, tag byte 0 flipped.
      wr(FLD_TAG, 8'd0, 4'b1000, 32'hEF000000);
      run_op(MODE_DEC, 0, 0, -1, 0, 3'd0, 8'd0, 4'h0, 32'h0);
      chk("dec_bad_auth", auth_ok, 0);
      chk("dec_bad_beats", got.size(), 16);
      chk("dec_bad_beat0", got[0], 8'h00);

      // Encrypt under backpressure, with writes and start during RUN.
      run_op(MODE_ENC, 1, 1, -1, 0, 3'd0, 8'd0, 4'h0, 32'h0);
      chk("bp_beats", got.size(), 32);
      chk("bp_tag16", got[16], 8'h10);

      // Reset during DRAIN of a passing decrypt, then re-enter.
      wr(FLD_TAG, 8'd0, 4'hF, 32'h10101010);
      run_op(MODE_DEC, 0, 0, 5, 0, 3'd0, 8'd0, 4'h0, 32'h0);
      for (int w = 0; w < 4; w++) begin
         tw = 32'h00010203 + 32'h04040404 * w;
         wr(FLD_KEY, 8'(w), 4'hF, tw);
         wr(FLD_NONCE, 8'(w), 4'hF, tw ^ 32'h10101010);
      end
      run_op(MODE_ENC, 0, 1, -1, 0, 3'd0, 8'd0, 4'h0, 32'h0);
      chk("reentry_beats", got.size(), 32);
      chk("reentry_beat0", got[0], 8'hA5);

      // Randomised operations.
      for (int it = 0; it < 16; it++) begin
         logic md;
         repeat (6) wr(3'($urandom_range(0, 7)), 8'($urandom_range(0, 5)),
                       4'($urandom), $urandom);
         md = ($urandom_range(0, 1) != 0);
         if (md && $urandom_range(0, 1) != 0)
            for (int w = 0; w < 4; w++) begin
               for (int L = 0; L < 4; L++) tw = {tw[23:0], mb[0][w*4+L] ^ mb[1][w*4+L]};
               wr(FLD_TAG, 8'(w), 4'hF, tw);
            end
         run_op(md, 2, (it % 4 == 0), -1, (it % 3 == 0),
                3'($urandom_range(0, 4)), 8'($urandom_range(0, 3)), 4'($urandom), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
